scl_edge: RTL and testbench



---
 rtl/scl_edge_if.sv | 19 +
 rtl/scl_edge.sv | 68 ++++++
 tb/tb_scl_edge.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/scl_edge_if.sv
// scl_edge_if: SCL line plus the two edge strobes, grouped for the scl_edge front end.
// The master side drives SCL; the slave side (scl_edge) returns the edge pulses.
interface scl_edge_if;
   logic scl;
   logic rising_edge_found;
   logic falling_edge_found;

   modport master (
      output scl,
      input  rising_edge_found,
      input  falling_edge_found
   );

   modport slave (
      input  scl,
      output rising_edge_found,
      output falling_edge_found
   );
endinterface

// File: rtl/scl_edge.sv
// scl_edge: samples SCL into the clk domain and emits one-cycle rising/falling edge strobes.
// Define SCL_EDGE_SYNC_EN to insert a two-flop synchronizer ahead of the edge sampler.
module scl_edge #(
   parameter logic IDLE_LEVEL = 1'b1
) (
   input logic       clk,
   input logic       rst,
   scl_edge_if.slave bus
);

   logic scl_in_s;
   logic scl_cur_q;
   logic scl_cur_d;
   logic scl_prev_q;
   logic scl_prev_d;
   logic rise_s;
   logic fall_s;

`ifdef SCL_EDGE_SYNC_EN
   logic [1:0] sync_q;
   logic [1:0] sync_d;

   // Synchronizer shift: raw SCL enters bit 0, bit 1 is the settled copy.
   always_comb begin
      sync_d = {sync_q[0], bus.scl};
   end

   // Synchronizer flops, reloaded to the idle bus level on reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q <= {IDLE_LEVEL, IDLE_LEVEL};
      end else begin
         sync_q <= sync_d;
      end
   end

   assign scl_in_s = sync_q[1];
`else
   assign scl_in_s = bus.scl;
`endif

   // Sample history: current sample and the one before it.
   always_comb begin
      scl_cur_d  = scl_in_s;
      scl_prev_d = scl_cur_q;
   end

   // History registers; reset loads the idle level so an idle bus yields no pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         scl_cur_q  <= IDLE_LEVEL;
         scl_prev_q <= IDLE_LEVEL;
      end else begin
         scl_cur_q  <= scl_cur_d;
         scl_prev_q <= scl_prev_d;
      end
   end

   // Edge decode from registers only, so the strobes never see raw SCL glitches.
   always_comb begin
      rise_s = scl_cur_q & ~scl_prev_q;
      fall_s = ~scl_cur_q & scl_prev_q;
   end

   assign bus.rising_edge_found  = rise_s;
   assign bus.falling_edge_found = fall_s;

endmodule

// File: tb/tb_scl_edge.sv
// tb_scl_edge: randomized and directed stimulus for scl_edge, checked every cycle against a
// delay-line model of the sampled SCL stream plus hand-computed literal expectations.
module tb_scl_edge;

`ifdef SCL_EDGE_SYNC_EN
   localparam int DEPTH = 4;
`else
   localparam int DEPTH = 2;
`endif

   logic clk;
   logic rst;
   int   total;
   int   bad;

   scl_edge_if bus_if ();

   scl_edge #(.IDLE_LEVEL(1'b1)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Model: samples of SCL taken at each posedge, newest at index 0; reset refills with idle.
   logic samp [0:DEPTH-1];
   bit   model_valid;

   initial begin
      total       = 0;
      bad         = 0;
      model_valid = 1'b0;
      for (int i = 0; i < DEPTH; i++) samp[i] = 1'b1;
   end

   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) samp[i] = 1'b1;
         model_valid = 1'b1;
      end else begin
         for (int i = DEPTH - 1; i > 0; i--) samp[i] = samp[i-1];
         samp[0] = bus_if.scl;
      end
   end

   // Per-cycle compare against the model, plus mutual exclusion.
   always @(negedge clk) begin
      logic exp_r;
      logic exp_f;
      if (model_valid) begin
         exp_r = (samp[DEPTH-2] == 1'b1) && (samp[DEPTH-1] == 1'b0);
         exp_f = (samp[DEPTH-2] == 1'b0) && (samp[DEPTH-1] == 1'b1);
         total++;
         if (bus_if.rising_edge_found !== exp_r) begin
            bad++;
            $display("FAIL model_rise t=%0t got=%b exp=%b", $time, bus_if.rising_edge_found, exp_r);
         end
         total++;
         if (bus_if.falling_edge_found !== exp_f) begin
            bad++;
            $display("FAIL model_fall t=%0t got=%b exp=%b", $time, bus_if.falling_edge_found, exp_f);
         end
         total++;
         if ((bus_if.rising_edge_found & bus_if.falling_edge_found) !== 1'b0) begin
            bad++;
            $display("FAIL mutex t=%0t got rise=%b fall=%b exp not both 1", $time,
                     bus_if.rising_edge_found, bus_if.falling_edge_found);
         end
      end
   end

   task automatic chk(input string name, input logic act, input logic exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s t=%0t got=%b exp=%b", name, $time, act, exp);
      end
   endtask

   task automatic settle(input logic v, input int n);
      bus_if.scl = v;
      repeat (n) @(negedge clk);
   endtask

   initial begin
      logic [2:0] pat;
      bus_if.scl = 1'b0;
      rst        = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         @(negedge clk);
`ifndef SCL_EDGE_SYNC_EN
         if (i == 1) chk("post_rst_fall", bus_if.falling_edge_found, 1'b1);
         if (i >= 3) begin
            chk("rst_settle_rise", bus_if.rising_edge_found, 1'b0);
            chk("rst_settle_fall", bus_if.falling_edge_found, 1'b0);
         end
`endif
         if (i == 4) begin
            chk("rst_final_rise", bus_if.rising_edge_found, 1'b0);
            chk("rst_final_fall", bus_if.falling_edge_found, 1'b0);
         end
      end

`ifndef SCL_EDGE_SYNC_EN
      // All 3-bit sample patterns; only the last two samples matter.
      for (int p = 0; p < 8; p++) begin
         pat = 3'(p);
         settle(pat[2], 1);
         settle(pat[1], 1);
         settle(pat[0], 1);
         chk("pat_rise", bus_if.rising_edge_found, (pat[1] == 1'b0) && (pat[0] == 1'b1));
         chk("pat_fall", bus_if.falling_edge_found, (pat[1] == 1'b1) && (pat[0] == 1'b0));
      end

      bus_if.scl = 1'b1;
      for (int i = 1; i <= 10; i++) begin
         @(negedge clk);
         if (i >= 2) begin
            chk("steady_rise", bus_if.rising_edge_found, 1'b0);
            chk("steady_fall", bus_if.falling_edge_found, 1'b0);
         end
      end

      for (int i = 0; i < 6; i++) begin
         bus_if.scl = (i % 2 == 0) ? 1'b0 : 1'b1;
         @(negedge clk);
         chk("toggle_rise", bus_if.rising_edge_found, bus_if.scl);
         chk("toggle_fall", bus_if.falling_edge_found, ~bus_if.scl);
      end
`endif

      // Sub-cycle glitch that no posedge samples.
      settle(1'b0, 6);
      bus_if.scl = 1'b1;
      #2 bus_if.scl = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("glitch_rise", bus_if.rising_edge_found, 1'b0);
         chk("glitch_fall", bus_if.falling_edge_found, 1'b0);
      end

      // Reset asserted while a rising pulse is pending.
      settle(1'b0, 4);
      bus_if.scl = 1'b1;
      @(negedge clk);
`ifndef SCL_EDGE_SYNC_EN
      chk("midrst_pulse", bus_if.rising_edge_found, 1'b1);
`endif
      rst = 1'b1;
      @(negedge clk);
      chk("midrst_rise", bus_if.rising_edge_found, 1'b0);
      chk("midrst_cur", dut.scl_cur_q, 1'b1);
      chk("midrst_prev", dut.scl_prev_q, 1'b1);
      rst = 1'b0;
      settle(1'b1, 5);

`ifdef SCL_EDGE_SYNC_EN
      settle(1'b0, 6);
      bus_if.scl = 1'b1;
      for (int k = 1; k <= 5; k++) begin
         @(negedge clk);
         chk("sync_lat_rise", bus_if.rising_edge_found, k == 3);
         chk("sync_lat_fall", bus_if.falling_edge_found, 1'b0);
      end
`endif

      // Randomized runs of SCL with occasional resets.
      for (int i = 0; i < 800; i++) begin
         if ($urandom_range(0, 2) == 0) bus_if.scl = 1'($urandom_range(0, 1));
         rst = ($urandom_range(0, 59) == 0);
         @(negedge clk);
      end
      rst = 1'b0;
      repeat (6) @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
